pwm_dac: RTL and testbench
==========================

PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 Parameter DIV, default 1, clock cycles per PWM tick, legal range 1..256.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserting it clears all state immediately.
REQ-004 enable  input  1  run PWM; low forces output low and holds counters at zero.
REQ-005 sample_in  input  8  next duty value, from the mixer output.
REQ-006 sample_valid  input  1  sample_in is offered this cycle.
REQ-007 sample_ready  output  1  pending buffer empty; the offer is accepted when valid and ready are both high.
REQ-008 clr_flags  input  1  one-cycle pulse clearing the sticky flags.
REQ-009 pwm_out  output  1  registered PWM bit to the pin.
REQ-010 period_start  output  1  one-cycle pulse marking a new PWM period.
REQ-011 underrun  output  1  sticky: a period started with no pending sample.
REQ-012 overrun  output  1  sticky: a sample was offered while the buffer was full.

Function
REQ-013 The prescaler shall count 0..DIV-1 while enable=1; tick is high in the cycle where prescaler==DIV-1, and the prescaler then wraps to 0.
REQ-014 The 8-bit period counter cnt shall increment on each tick and wrap 255->0, giving 256 ticks per period.
REQ-015 wrap is defined as a tick with cnt==255.
REQ-016 The pending buffer shall load sample_in and set pend_full on valid&&ready, and sample_ready shall equal !pend_full.
REQ-017 Valid with ready=0 shall drop the sample, leave the buffer unchanged and set overrun.
REQ-018 On wrap with pend_full=1, duty shall load the buffer and pend_full shall clear; the new duty takes effect from cnt=0.
REQ-019 On wrap with pend_full=0, duty shall be held and underrun shall be set.
REQ-020 Simultaneous wrap and valid with pend_full=1: the buffer moves to duty, the incoming sample is dropped, and overrun is set (ready was 0 that cycle).
REQ-021 Simultaneous wrap and valid with pend_full=0: underrun is set, duty is held, and the sample loads the buffer for the next wrap.
REQ-022 pwm_out(t+1) shall equal enable(t) && (cnt(t) < duty(t)), evaluated in every cycle, not only on ticks.
REQ-023 duty=0 shall produce a constant low output; duty=N shall produce high for N of every 256 ticks; duty=255 shall produce high for 255 of every 256 ticks.
REQ-024 period_start shall be high exactly one cycle, in the cycle after each wrap.
REQ-025 With enable=0:
- the prescaler and cnt are held at 0;
- pwm_out is 0 and there are no ticks, wraps or period_start pulses;
- duty is retained;
- the buffer still accepts a sample when empty.
REQ-026 On the first cycle with enable=1 after enable=0, counting shall start from cnt=0 and prescaler=0.
REQ-027 clr_flags shall clear underrun and overrun on the next edge; if set and clear occur in the same cycle, set wins.
REQ-028 All arithmetic shall be unsigned; the prescaler shall be sized to hold DIV-1 without overflow.

Reset
REQ-029 While rst=0, the following shall hold, independent of clk:
- prescaler=0, cnt=0, duty=0, pend=0, pend_full=0;
- pwm_out=0, period_start=0, underrun=0, overrun=0;
- sample_ready=1.
REQ-030 Reset asserted mid-period shall discard the pending sample and the current duty; after release, the first wrap occurs 256*DIV cycles after the first enabled cycle.

Verification
REQ-031 DIV=1, enable=1, one sample 0x40 before the first wrap -> after that wrap, pwm_out is high 64 cycles and low 192 cycles per period; period_start pulses every 256 cycles.
REQ-032 Samples 0x00 then 0xFF, one per period -> first period constant 0; second period high 255 ticks, low at cnt=255; no underrun, no overrun.
REQ-033 No sample supplied across a wrap -> underrun=1 and duty unchanged; a clr_flags pulse -> underrun=0 the next cycle.
REQ-034 Two valid samples back-to-back with no intervening wrap -> second is dropped and overrun=1; sample_ready stays 0 until the wrap.
REQ-035 Valid on the wrap cycle, once with pend_full=1 and once with pend_full=0 -> behaviour per REQ-020 and REQ-021 respectively.
REQ-036 DIV=4, enable dropped mid-period, then rst pulsed low mid-period -> pwm_out goes to 0 and counters reset; after re-enable, the first period_start occurs 1024 cycles later.

Source files
------------

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC with prescaled tick, single-entry sample buffer and sticky underrun/overrun flags.
// pwm_out lags cnt/duty by one cycle; sample_ready drops while a sample is pending and new offers are dropped.
module pwm_dac #(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       clr_flags,
    output logic       pwm_out,
    output logic       period_start,
    output logic       underrun,
    output logic       overrun
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic [7:0]    cnt;
    logic [7:0]    duty;
    logic [7:0]    pend;
    logic          pend_full;

    logic tick;
    logic wrap;
    logic accept;
    logic load;
    logic set_under;
    logic set_over;

    assign tick         = enable && (pre == PRE_MAX);
    assign wrap         = tick && (cnt == 8'hFF);
    assign sample_ready = !pend_full;
    assign accept       = sample_valid && !pend_full;
    assign load         = wrap && pend_full;
    // An offer while full is dropped even on the wrap cycle: ready was low when it was made.
    assign set_over     = sample_valid && pend_full;
    assign set_under    = wrap && !pend_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (!enable) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (load) begin
            duty      <= pend;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend      <= sample_in;
            pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pwm_out      <= enable && (cnt < duty);
            period_start <= wrap;
            underrun     <= set_under || (underrun && !clr_flags);
            overrun      <= set_over || (overrun && !clr_flags);
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: DIV=1 and DIV=4 instances share stimulus and are checked against a tick-count model.
module tb_pwm_dac;

    localparam int DIV_A = 1;
    localparam int DIV_B = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clr_flags;
    logic [1:0] rdy_w;
    logic [1:0] pwm_w;
    logic [1:0] ps_w;
    logic [1:0] un_w;
    logic [1:0] ov_w;

    int npass  = 0;
    int ntotal = 0;

    pwm_dac #(.DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(rdy_w[0]), .clr_flags(clr_flags),
        .pwm_out(pwm_w[0]), .period_start(ps_w[0]), .underrun(un_w[0]), .overrun(ov_w[0])
    );

    pwm_dac #(.DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(rdy_w[1]), .clr_flags(clr_flags),
        .pwm_out(pwm_w[1]), .period_start(ps_w[1]), .underrun(un_w[1]), .overrun(ov_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int divof(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model: position in the period follows from the number of enabled cycles since enable rose.
    int         m_run   [2];
    int         m_cnt   [2];
    bit         m_tick  [2];
    bit         m_wrap  [2];
    logic [7:0] m_duty  [2];
    logic [7:0] m_pend  [2];
    bit         m_full  [2];
    bit         m_pwm   [2];
    bit         m_ps    [2];
    bit         m_under [2];
    bit         m_over  [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = (m_run[i] / divof(i)) % 256;
            m_tick[i] = enable && ((m_run[i] % divof(i)) == divof(i) - 1);
            m_wrap[i] = m_tick[i] && (m_cnt[i] == 255);
        end
    end

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_run[i]   <= 0;
                m_duty[i]  <= '0;
                m_pend[i]  <= '0;
                m_full[i]  <= 1'b0;
                m_pwm[i]   <= 1'b0;
                m_ps[i]    <= 1'b0;
                m_under[i] <= 1'b0;
                m_over[i]  <= 1'b0;
            end else begin
                m_pwm[i] <= enable && (m_cnt[i] < int'(m_duty[i]));
                m_ps[i]  <= m_wrap[i];
                if (m_wrap[i] && m_full[i]) begin
                    m_duty[i] <= m_pend[i];
                    m_full[i] <= 1'b0;
                end else if (sample_valid && !m_full[i]) begin
                    m_pend[i] <= sample_in;
                    m_full[i] <= 1'b1;
                end
                m_under[i] <= (m_wrap[i] && !m_full[i]) || (m_under[i] && !clr_flags);
                m_over[i]  <= (sample_valid && m_full[i]) || (m_over[i] && !clr_flags);
                m_run[i]   <= enable ? m_run[i] + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cycle_dut%0d{rdy,pwm,ps,un,ov}", i),
                  int'({rdy_w[i], pwm_w[i], ps_w[i], un_w[i], ov_w[i]}),
                  int'({!m_full[i], m_pwm[i], m_ps[i], m_under[i], m_over[i]}));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one DIV=1 period starting from a period_start cycle; counts high cycles of dut_a.
    task automatic run_period(input bit clr, input bit v0, input logic [7:0] s0,
                              input bit v1, input logic [7:0] s1,
                              input bit vw, input logic [7:0] sw, output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            clr_flags    = clr && (i == 0);
            sample_valid = (i == 0 && v0) || (i == 1 && v1) || (i == 255 && vw);
            sample_in    = (i == 0) ? s0 : (i == 1) ? s1 : sw;
            step();
            hi += int'(pwm_w[0]);
            if (clr && i == 0) check("clr_flags_cleared", int'({un_w[0], ov_w[0]}), 0);
            if (v1 && i == 1) begin
                check("b2b_ready_low", int'(rdy_w[0]), 0);
                check("b2b_overrun", int'(ov_w[0]), 1);
            end
            if (v1 && i == 128) check("b2b_ready_held_low", int'(rdy_w[0]), 0);
        end
        clr_flags    = 1'b0;
        sample_valid = 1'b0;
        check("period_len_256", int'(ps_w[0]), 1);
    endtask

    int n;
    int n0;
    int n1;
    int hi;

    initial begin
        rst = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0; clr_flags = 1'b0;
        repeat (3) step();
        check("rst_ready", int'(rdy_w), 3);
        check("rst_pwm", int'(pwm_w), 0);
        check("rst_flags", int'({un_w, ov_w, ps_w}), 0);

        rst = 1'b1; enable = 1'b1; sample_valid = 1'b1; sample_in = 8'h40;
        step();
        sample_valid = 1'b0;
        n = 1;
        while (!ps_w[0] && n < 600) begin
            step();
            n++;
        end
        check("first_wrap_cycles", n, 256);
        check("ready_after_load", int'(rdy_w[0]), 1);

        run_period(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, hi);
        check("duty40_high", hi, 64);
        check("underrun_set", int'(un_w[0]), 1);

        run_period(1, 1, 8'h00, 0, 8'h00, 0, 8'h00, hi);
        check("duty_held_after_underrun", hi, 64);

        run_period(0, 1, 8'hFF, 0, 8'h00, 0, 8'h00, hi);
        check("duty00_high", hi, 0);
        check("no_flags_00_ff", int'({un_w[0], ov_w[0]}), 0);

        run_period(0, 1, 8'h10, 1, 8'h20, 0, 8'h00, hi);
        check("dutyFF_high", hi, 255);
        check("overrun_sticky", int'(ov_w[0]), 1);

        run_period(1, 1, 8'h30, 0, 8'h00, 1, 8'h50, hi);
        check("duty10_first_kept", hi, 16);
        check("wrap_full_overrun", int'({un_w[0], ov_w[0]}), 1);
        check("wrap_full_ready", int'(rdy_w[0]), 1);

        run_period(1, 0, 8'h00, 0, 8'h00, 1, 8'h60, hi);
        check("duty30_high", hi, 48);
        check("wrap_empty_underrun", int'({un_w[0], ov_w[0]}), 2);
        check("wrap_empty_buffered", int'(rdy_w[0]), 0);

        run_period(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, hi);
        check("duty_held_on_underrun", hi, 48);
        check("buffer_moved", int'(rdy_w[0]), 1);

        run_period(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, hi);
        check("duty60_high", hi, 96);

        repeat (100) step();
        enable = 1'b0;
        step();
        check("disable_pwm_low", int'(pwm_w), 0);
        sample_valid = 1'b1; sample_in = 8'h77;
        step();
        sample_valid = 1'b0;
        check("accept_while_disabled", int'(rdy_w), 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_mid_ready", int'(rdy_w), 3);
        check("rst_mid_outputs", int'({pwm_w, un_w, ov_w}), 0);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        enable = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (ps_w[0] && n0 == 0) n0 = k;
            if (ps_w[1] && n1 == 0) n1 = k;
        end
        check("reenable_wrap_div1", n0, 256);
        check("reenable_wrap_div4", n1, 1024);
        check("div4_pwm_after_rst", int'(pwm_w[1]), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
